spi_frame_sequencer: RTL

Two-requester scheduler that owns the `spi_master_slave` engine. Arbitrates round-robin between requester 0 (multiplier result path) and requester 1 (UART command bridge). Sequences each 16-bit frame: freq setup, start pulse, wait for `rx_valid`, inter-frame gap. Returns received data, and a timeout error, to the granted requester.

---
 rtl/spi_seq_pkg.sv | 8 +
 rtl/spi_seq_if.sv | 27 ++
 rtl/spi_seq_rr_arb.sv | 10 +
 rtl/spi_frame_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared types and constants for the SPI frame sequencer
package spi_seq_pkg;
  localparam int SPI_WORD_W = 16;
  localparam int SPI_FREQ_W = 2;
  localparam int REQ_MULT   = 0;
  localparam int REQ_UART   = 1;
  typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, WAIT_RX, GAP} state_t;
endpackage

// File: rtl/spi_seq_if.sv
// spi_seq_if: requester-side and SPI-engine-side signals of the frame sequencer
interface spi_seq_if;
  logic [1:0]                          req;
  logic [1:0]                          req_wr;
  logic [spi_seq_pkg::SPI_WORD_W-1:0]  req_wdata0;
  logic [spi_seq_pkg::SPI_WORD_W-1:0]  req_wdata1;
  logic [spi_seq_pkg::SPI_FREQ_W-1:0]  req_freq0;
  logic [spi_seq_pkg::SPI_FREQ_W-1:0]  req_freq1;
  logic [1:0]                          done;
  logic                                err;
  logic [spi_seq_pkg::SPI_WORD_W-1:0]  rdata;
  logic                                busy;
  logic                                spi_tx_start;
  logic                                spi_rx_start;
  logic [spi_seq_pkg::SPI_WORD_W-1:0]  spi_tx_data;
  logic [spi_seq_pkg::SPI_FREQ_W-1:0]  spi_freq;
  logic                                spi_rx_valid;
  logic [spi_seq_pkg::SPI_WORD_W-1:0]  spi_rx_data;
  modport slave (
    input  req, req_wr, req_wdata0, req_wdata1, req_freq0, req_freq1, spi_rx_valid, spi_rx_data,
    output done, err, rdata, busy, spi_tx_start, spi_rx_start, spi_tx_data, spi_freq
  );
  modport master (
    output req, req_wr, req_wdata0, req_wdata1, req_freq0, req_freq1, spi_rx_valid, spi_rx_data,
    input  done, err, rdata, busy, spi_tx_start, spi_rx_start, spi_tx_data, spi_freq
  );
endinterface

// File: rtl/spi_seq_rr_arb.sv
// spi_seq_rr_arb: combinational 2-way round-robin arbiter
module spi_seq_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx,
  output logic       gnt_valid
);
  assign gnt_valid = |req;
  assign gnt_idx   = &req ? ~last : req[1];
endmodule

// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer: round-robin two-requester scheduler sequencing 16-bit frames on an SPI master
module spi_frame_sequencer
  import spi_seq_pkg::*;
#(
  parameter int GAP_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input logic      clk,
  input logic      reset_n,
  spi_seq_if.slave bus
);
  // Timeout fires on the edge where the counter would reach TIMEOUT_CYCLES-1, so err lands TIMEOUT_CYCLES after LAUNCH
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES == 0 ? 0 : GAP_CYCLES - 1);
  state_t                  r_state, w_state;
  logic                    r_last, w_last;
  logic                    r_gnt, w_gnt;
  logic                    r_wr, w_wr;
  logic [CNT_W-1:0]        r_cnt, w_cnt;
  logic [1:0]              r_done, w_done;
  logic                    r_err, w_err;
  logic [SPI_WORD_W-1:0]   r_rdata, w_rdata;
  logic                    r_tx_start, w_tx_start;
  logic                    r_rx_start, w_rx_start;
  logic [SPI_WORD_W-1:0]   r_tx_data, w_tx_data;
  logic [SPI_FREQ_W-1:0]   r_freq, w_freq;
  logic                    w_gnt_idx, w_gnt_valid;
  spi_seq_rr_arb u_arb (
    .req       (bus.req),
    .last      (r_last),
    .gnt_idx   (w_gnt_idx),
    .gnt_valid (w_gnt_valid)
  );
  always_comb begin
    w_state    = r_state;
    w_last     = r_last;
    w_gnt      = r_gnt;
    w_wr       = r_wr;
    w_cnt      = r_cnt;
    w_done     = '0;
    w_err      = 1'b0;
    w_rdata    = r_rdata;
    w_tx_start = 1'b0;
    w_rx_start = 1'b0;
    w_tx_data  = r_tx_data;
    w_freq     = r_freq;
    unique case (r_state)
      IDLE: if (w_gnt_valid) begin
        w_state   = SETUP;
        w_gnt     = w_gnt_idx;
        w_last    = w_gnt_idx;
        w_wr      = bus.req_wr[w_gnt_idx];
        w_tx_data = !w_wr ? '0 : w_gnt_idx ? bus.req_wdata1 : bus.req_wdata0;
        w_freq    = w_gnt_idx ? bus.req_freq1 : bus.req_freq0;
      end
      // Start pulses are registered on this edge so they are visible exactly during LAUNCH
      SETUP: begin
        w_state    = LAUNCH;
        w_rx_start = 1'b1;
        w_tx_start = r_wr;
      end
      LAUNCH: begin
        w_state = WAIT_RX;
        w_cnt   = '0;
      end
      WAIT_RX: begin
        w_cnt = r_cnt + CNT_W'(1);
        if (bus.spi_rx_valid) begin
          w_rdata       = bus.spi_rx_data;
          w_done[r_gnt] = 1'b1;
          w_cnt         = '0;
          w_state       = GAP;
        end else if (r_cnt == TO_LAST) begin
          w_done[r_gnt] = 1'b1;
          w_err         = 1'b1;
          w_cnt         = '0;
          w_state       = GAP;
        end
      end
      GAP: begin
        w_cnt   = r_cnt == GAP_LAST ? '0 : r_cnt + CNT_W'(1);
        w_state = r_cnt == GAP_LAST ? IDLE : GAP;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_gnt      <= 1'b0;
      r_wr       <= 1'b0;
      r_cnt      <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_tx_start <= 1'b0;
      r_rx_start <= 1'b0;
      r_tx_data  <= '0;
      r_freq     <= '0;
    end else begin
      r_state    <= w_state;
      r_last     <= w_last;
      r_gnt      <= w_gnt;
      r_wr       <= w_wr;
      r_cnt      <= w_cnt;
      r_done     <= w_done;
      r_err      <= w_err;
      r_rdata    <= w_rdata;
      r_tx_start <= w_tx_start;
      r_rx_start <= w_rx_start;
      r_tx_data  <= w_tx_data;
      r_freq     <= w_freq;
    end
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.rdata        = r_rdata;
  assign bus.busy         = r_state != IDLE;
  assign bus.spi_tx_start = r_tx_start;
  assign bus.spi_rx_start = r_rx_start;
  assign bus.spi_tx_data  = r_tx_data;
  assign bus.spi_freq     = r_freq;
endmodule
